// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing defaults, colour constants and a helper that
// narrows integer timing constants to the 10-bit counter width.
package vga_timing_pkg;

  localparam int VGA_CLK_DIV      = 4;
  localparam int VGA_H_TOTAL      = 800;
  localparam int VGA_H_SYNC       = 96;
  localparam int VGA_H_DISP_START = 144;
  localparam int VGA_H_DISP_END   = 783;
  localparam int VGA_V_TOTAL      = 525;
  localparam int VGA_V_SYNC       = 2;
  localparam int VGA_V_DISP_START = 35;
  localparam int VGA_V_DISP_END   = 514;

  localparam int CNT_W   = 10;
  localparam int COLOR_W = 12;

  localparam logic [COLOR_W-1:0] BLACK  = 12'h000;
  localparam logic [COLOR_W-1:0] WHITE  = 12'hFFF;
  localparam logic [COLOR_W-1:0] RED    = 12'hF00;
  localparam logic [COLOR_W-1:0] GREEN  = 12'h0F0;
  localparam logic [COLOR_W-1:0] BLUE   = 12'h00F;
  localparam logic [COLOR_W-1:0] PINK   = 12'hF0F;
  localparam logic [COLOR_W-1:0] PURPLE = 12'h80F;
  localparam logic [COLOR_W-1:0] YELLOW = 12'hFF0;

  // Timing constants are small non-negative integers; all counter compares
  // are done at the 10-bit counter width.
  function automatic logic [CNT_W-1:0] cnt10(input int value);
    return CNT_W'(value);
  endfunction

endpackage

// File: rtl/pix_en_div.sv
// Pixel clock-enable generator: one-clk strobe every CLK_DIV system clocks,
// so the raster logic runs on the fast clock without a derived clock.
module pix_en_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_cnt;

  // Free-running divider 0..CLK_DIV-1; with CLK_DIV=1 it sits at 0 and the strobe stays high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  assign pix_en = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, visible-window decode, registered
// colour and sync pins (one pixel behind the counters) and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV      = VGA_CLK_DIV,
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_DISP_START = VGA_H_DISP_START,
  parameter int H_DISP_END   = VGA_H_DISP_END,
  parameter int V_TOTAL      = VGA_V_TOTAL,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_DISP_START = VGA_V_DISP_START,
  parameter int V_DISP_END   = VGA_V_DISP_END
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [CNT_W-1:0]   hCount,
  output logic [CNT_W-1:0]   vCount,
  output logic               bright,
  output logic               line_tick,
  output logic               frame_tick,
  input  logic [COLOR_W-1:0] rgb_in,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               hSync,
  output logic               vSync
);

  localparam logic [CNT_W-1:0] H_LAST    = cnt10(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = cnt10(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_W  = cnt10(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_W  = cnt10(V_SYNC);
  localparam logic [CNT_W-1:0] H_VIS_LO  = cnt10(H_DISP_START);
  localparam logic [CNT_W-1:0] H_VIS_HI  = cnt10(H_DISP_END);
  localparam logic [CNT_W-1:0] V_VIS_LO  = cnt10(V_DISP_START);
  localparam logic [CNT_W-1:0] V_VIS_HI  = cnt10(V_DISP_END);

  logic               line_end;
  logic [COLOR_W-1:0] rgb_q;

  pix_en_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_en_div (
    .clk   (clk),
    .rst   (rst),
    .pix_en(pix_en)
  );

  assign line_end = pix_en && (hCount == H_LAST);

  // Raster position: column advances each pixel, line advances when the column wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (hCount == H_LAST) begin
        hCount <= '0;
        vCount <= (vCount == V_LAST) ? '0 : vCount + 10'd1;
      end else begin
        hCount <= hCount + 10'd1;
      end
    end
  end

  assign bright = (hCount >= H_VIS_LO) && (hCount <= H_VIS_HI) &&
                  (vCount >= V_VIS_LO) && (vCount <= V_VIS_HI);

  // Pin stage: colour blanked outside the window, syncs active-low, all loaded together once per pixel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_q <= '0;
      hSync <= 1'b1;
      vSync <= 1'b1;
    end else if (pix_en) begin
      rgb_q <= bright ? rgb_in : '0;
      hSync <= (hCount >= H_SYNC_W);
      vSync <= (vCount >= V_SYNC_W);
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];

  // End-of-line and end-of-visible-frame strobes, one clk wide, cleared by reset so an aborted frame emits nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      line_tick  <= line_end;
      frame_tick <= line_end && (vCount == V_VIS_HI);
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Produces the 640×480@60 Hz raster timing that the block controllers consume: `hCount`, `vCount`, `bright`, and the sync pulses.
- Derives a pixel clock-enable from the fast system clock, so the whole design runs on one clock.
- Registers the controller's `rgb` into the pins with blanking applied and keeps the syncs aligned to it.
- Emits per-line and per-frame strobes; game-state logic uses these instead of a separate slow clock.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz → 25 MHz); legal range 1–16.
- `H_TOTAL`, 800: pixel periods per line.
- `H_SYNC`, 96: hSync pulse width; hSync active for `hCount` 0..95.
- `H_DISP_START`, 144: first visible column.
- `H_DISP_END`, 783: last visible column.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC`, 2: vSync pulse width; vSync active for `vCount` 0..1.
- `V_DISP_START`, 35: first visible line.
- `V_DISP_END`, 514: last visible line.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, synchronous and active-low.
- `pix_en` out 1: one-`clk` pixel strobe.
- `hCount` out 10: current column, 0..`H_TOTAL`-1.
- `vCount` out 10: current line, 0..`V_TOTAL`-1.
- `bright` out 1: current (`hCount`,`vCount`) is in the visible window.
- `line_tick` out 1: one-`clk` pulse at end of each line.
- `frame_tick` out 1: one-`clk` pulse at end of the last visible line.
- `rgb_in` in 12: pixel colour {R,G,B} from the block controller for the current counters.
- `vga_r`, `vga_g`, `vga_b` out 4 each: registered colour to the DAC pins.
- `hSync`, `vSync` out 1: registered syncs, active-low.

## Operation
Divider:
- `div_cnt` counts 0..`CLK_DIV`-1.
- `pix_en`=1 exactly when `div_cnt`==`CLK_DIV`-1.
- With `CLK_DIV`=1, `pix_en` is constantly 1 after reset.

Counters (advance only on `pix_en` cycles):
- `hCount`+1; at `H_TOTAL`-1 it wraps to 0 and `vCount` increments.
- `vCount` wraps from `V_TOTAL`-1 to 0 when `hCount` wraps.

`bright`:
- Combinational from the registered counters.
- Equals (`H_DISP_START`≤`hCount`≤`H_DISP_END`) && (`V_DISP_START`≤`vCount`≤`V_DISP_END`).
- Inclusive bounds: 640×480 visible.

Output stage (registered on `pix_en` cycles only; holds otherwise):
- {`vga_r`,`vga_g`,`vga_b`} ← `bright` ? `rgb_in` : 0.
- `hSync` ← !(`hCount` < `H_SYNC`).
- `vSync` ← !(`vCount` < `V_SYNC`).

Strobes (registered, high for one `clk`):
- `line_tick`: asserted in the `clk` after a `pix_en` cycle with `hCount`==`H_TOTAL`-1.
- `frame_tick`: same condition plus `vCount`==`V_DISP_END`, so game logic updates during vertical blank.
- `frame_tick` implies `line_tick` in the same cycle.

## Timing
Reset (`rst`=0 at a `clk` edge):
- `div_cnt`, `hCount`, `vCount` = 0.
- RGB pins = 0; `hSync`=`vSync`=1 (deasserted).
- `line_tick`=`frame_tick`=0; `pix_en`=0 (or 1 if `CLK_DIV`=1).
- Reset mid-frame aborts the frame immediately; no partial strobe is emitted.

After reset release:
- First `pix_en` occurs `CLK_DIV`-1 `clk` cycles later, i.e. on the `CLK_DIV`th `clk`.
- First output-stage load drives `hSync`=0 and `vSync`=0, because the counters are at (0,0).

Latency:
- Pins lag the counters by exactly one pixel period (`CLK_DIV` clocks).
- Colour, `hSync` and `vSync` are mutually aligned on the pins.
- `rgb_in` must be stable for the whole pixel period; it is sampled only on `pix_en` cycles.

Frame rate: one frame = `H_TOTAL`·`V_TOTAL`·`CLK_DIV` = 1 680 000 `clk` at defaults.

## Structure
- Package `vga_timing_pkg` holds the nine timing defaults, the colour constants (RED, WHITE, PINK, BLUE, PURPLE, BLACK, …) and the 12-bit colour width.
- All timing arithmetic is 10-bit unsigned, with compares against constants only.
- One sub-module: `pix_en_div` (parameter `CLK_DIV`; ports `clk`, `rst`, `pix_en`).
- Counters, sync/bright decode and the output register live in the top module.

## Test plan
- Reset and strobe: hold `rst`=0 3 clks, release → pins 0, syncs 1, counters 0; `pix_en` first high on 4th clk, then every 4th clk.
- Line wrap: run to `hCount`=799 → next `pix_en` gives `hCount`=0 and `vCount`+1; `line_tick` high exactly 1 clk.
- Sync widths: `hSync` low for 96·4=384 clks per line; `vSync` low for 2 lines = 6400 clks; frame period 1 680 000 clks.
- Blanking: `rgb_in`=12'hF0F constant → pins show F/0/F only for 640 px on each of 480 lines; 0 at `hCount`=143/784 and `vCount`=34/515, observed one pixel later.
- `frame_tick`: exactly one pulse per frame, coinciding with the `line_tick` at the end of `vCount`=514; assert `rst` at `vCount`=300 → no `frame_tick`, counters 0 next clk.
- `CLK_DIV`=1: `pix_en` constantly 1; frame period 420 000 clks; pin lag 1 clk.
